// File: rtl/upstream_lock_ctrl.sv
// Upstream passage controller for one canal-lock boat.
// The boat enters at the downstream gate (gate2), the water is raised, and
// the boat leaves through the upstream gate (gate1). The block drives the
// direction LEDs and keeps a wrap-around count of completed passages.
module upstream_lock_ctrl #(
    parameter int ARR_CYCLES = 1500,
    parameter int CNT_W      = 11,
    parameter int PASS_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arr_sw,
    input  logic              dep_sw,
    input  logic              gate2_sw,
    input  logic              gate1_sw,
    input  logic              water_high,
    input  logic              water_low,
    output logic              arr_li,
    output logic              dep_li,
    output logic              gate2_li,
    output logic              gate1_li,
    output logic              occupied,
    output logic              exited,
    output logic [PASS_W-1:0] pass_count
);

    typedef enum logic [2:0] {
        IDLE,
        ARRIVING,
        WAIT_LOW,
        GATE2_OPEN,
        OCCUPIED,
        GATE1_OPEN,
        EXITED
    } state_t;

    localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_CYCLES - 1);

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] timer;

    // A water flag is trusted only when the other one is low; both high means
    // the level sensors disagree, so neither gate may open.
    logic low_ok;
    logic high_ok;
    assign low_ok  = water_low  & ~water_high;
    assign high_ok = water_high & ~water_low;

    // Next-state rule for one rising edge, kept as a pure function so the
    // registered outputs below can be decoded from the state being entered.
    function automatic state_t next_state(
        input state_t           cur,
        input logic [CNT_W-1:0] tmr,
        input logic             arr,
        input logic             dep,
        input logic             g2,
        input logic             g1,
        input logic             lo_ok,
        input logic             hi_ok
    );
        // NOTE: the result is assigned before the case so every path yields a
        // value; a branch that forgot to assign would otherwise imply storage.
        next_state = cur;
        case (cur)
            IDLE:       if (arr) next_state = ARRIVING;
            ARRIVING: begin
                if (!arr)                 next_state = IDLE;
                else if (tmr == ARR_LAST) next_state = WAIT_LOW;
            end
            WAIT_LOW:   if (lo_ok && g2) next_state = GATE2_OPEN;
            GATE2_OPEN: if (!g2) next_state = OCCUPIED;
            OCCUPIED:   if (dep && hi_ok && g1) next_state = GATE1_OPEN;
            GATE1_OPEN: if (!g1 && !dep) next_state = EXITED;
            EXITED:     next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    endfunction

    assign nxt = next_state(state, timer, arr_sw, dep_sw, gate2_sw, gate1_sw,
                            low_ok, high_ok);

    // Departure request is echoed straight through while the boat is inside.
    assign dep_li = (state == OCCUPIED) && dep_sw;

    // State register, arrival timer, passage counter and registered Moore outputs.
    always_ff @(posedge clk) begin
        // NOTE: all state updates use non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            pass_count <= '0;
            arr_li     <= 1'b0;
            gate2_li   <= 1'b0;
            gate1_li   <= 1'b0;
            occupied   <= 1'b0;
            exited     <= 1'b0;
        end else begin
            state <= nxt;

            // The timer only advances while arrival keeps being confirmed.
            if (state == ARRIVING && nxt == ARRIVING)
                timer <= timer + 1'b1;
            else
                timer <= '0;

            // Counted on entry to EXITED; wraps naturally at 2^PASS_W.
            if (nxt == EXITED && state != EXITED)
                pass_count <= pass_count + 1'b1;

            arr_li   <= (nxt == WAIT_LOW);
            gate2_li <= (nxt == GATE2_OPEN);
            gate1_li <= (nxt == GATE1_OPEN);
            occupied <= (nxt == OCCUPIED);
            exited   <= (nxt == EXITED);
        end
    end

endmodule

// File: tb/tb_upstream_lock_ctrl.sv
// Directed bench for upstream_lock_ctrl with a 4-cycle arrival delay.
module tb_upstream_lock_ctrl;

    localparam int ARR_CYCLES = 4;
    localparam int CNT_W      = 3;
    localparam int PASS_W     = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              arr_sw, dep_sw, gate2_sw, gate1_sw;
    logic              water_high, water_low;
    logic              arr_li, dep_li, gate2_li, gate1_li, occupied, exited;
    logic [PASS_W-1:0] pass_count;

    int compared   = 0;
    int mismatched = 0;

    upstream_lock_ctrl #(
        .ARR_CYCLES(ARR_CYCLES),
        .CNT_W     (CNT_W),
        .PASS_W    (PASS_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .arr_sw    (arr_sw),
        .dep_sw    (dep_sw),
        .gate2_sw  (gate2_sw),
        .gate1_sw  (gate1_sw),
        .water_high(water_high),
        .water_low (water_low),
        .arr_li    (arr_li),
        .dep_li    (dep_li),
        .gate2_li  (gate2_li),
        .gate1_li  (gate1_li),
        .occupied  (occupied),
        .exited    (exited),
        .pass_count(pass_count)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed view of the registered lamps: {arr, gate2, gate1, occupied, exited}.
    function automatic logic [31:0] lamps();
        return {27'd0, arr_li, gate2_li, gate1_li, occupied, exited};
    endfunction

    // One complete passage starting from IDLE; ends back in IDLE.
    task automatic passage(input int n, input logic [PASS_W-1:0] exp_cnt);
        arr_sw = 1'b1;
        step();
        repeat (ARR_CYCLES) step();
        arr_sw = 1'b0; water_low = 1'b1; water_high = 1'b0; gate2_sw = 1'b1;
        step();
        gate2_sw = 1'b0;
        step();
        dep_sw = 1'b1; water_low = 1'b0; water_high = 1'b1; gate1_sw = 1'b1;
        step();
        dep_sw = 1'b0; gate1_sw = 1'b0;
        step();
        check($sformatf("loop%0d_exited", n), {31'd0, exited}, 32'd1);
        check($sformatf("loop%0d_count", n), {24'd0, pass_count}, {24'd0, exp_cnt});
        step();
        check($sformatf("loop%0d_exited_low", n), {31'd0, exited}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        arr_sw = 1'b0; dep_sw = 1'b0; gate2_sw = 1'b0; gate1_sw = 1'b0;
        water_high = 1'b0; water_low = 1'b0;
        step();
        check("reset_lamps", lamps(), 32'd0);
        check("reset_dep", {31'd0, dep_li}, 32'd0);
        check("reset_count", {24'd0, pass_count}, 32'd0);
        reset = 1'b0;

        // Arrival: first sampling edge, then 4 more edges to acknowledge.
        arr_sw = 1'b1;
        step();
        check("arr_edge0", lamps(), 32'd0);
        for (int i = 1; i < ARR_CYCLES; i++) begin
            step();
            check($sformatf("arr_edge%0d", i), lamps(), 32'd0);
        end
        step();
        check("arr_ack", lamps(), 32'b10000);
        arr_sw = 1'b0;
        gate1_sw = 1'b1;           // wrong gate for this state: ignored
        step();
        check("arr_latched", lamps(), 32'b10000);
        gate1_sw = 1'b0;

        // Full passage.
        water_low = 1'b1; gate2_sw = 1'b1;
        step();
        check("gate2_open", lamps(), 32'b01000);
        water_low = 1'b0;          // water changes ignored with gate open
        step();
        check("gate2_hold", lamps(), 32'b01000);
        gate2_sw = 1'b0;
        step();
        check("occupied", lamps(), 32'b00010);
        check("dep_idle", {31'd0, dep_li}, 32'd0);
        dep_sw = 1'b1;
        #1;
        check("dep_echo", {31'd0, dep_li}, 32'd1);
        water_high = 1'b1; gate1_sw = 1'b1;
        step();
        check("gate1_open", lamps(), 32'b00100);
        check("dep_after", {31'd0, dep_li}, 32'd0);
        gate1_sw = 1'b0;
        step();
        check("gate1_hold_dep", lamps(), 32'b00100);
        dep_sw = 1'b0;
        step();
        check("exit_pulse", lamps(), 32'b00001);
        check("exit_count", {24'd0, pass_count}, 32'd1);
        step();
        check("exit_done", lamps(), 32'd0);
        check("count_hold", {24'd0, pass_count}, 32'd1);

        // Short arrival pulse aborts; a full hold then succeeds.
        arr_sw = 1'b1;
        step();
        step();
        arr_sw = 1'b0;
        step();
        check("pulse_abort", lamps(), 32'd0);
        repeat (ARR_CYCLES) step();
        check("pulse_no_ack", lamps(), 32'd0);
        arr_sw = 1'b1;
        for (int i = 0; i < ARR_CYCLES; i++) begin
            step();
            check($sformatf("rearr_edge%0d", i), lamps(), 32'd0);
        end
        step();
        check("rearr_ack", lamps(), 32'b10000);
        arr_sw = 1'b0;

        // Contradictory water flags block the gate2 transition.
        water_high = 1'b1; water_low = 1'b1; gate2_sw = 1'b1;
        step();
        check("both_flags_a", lamps(), 32'b10000);
        step();
        check("both_flags_b", lamps(), 32'b10000);
        water_high = 1'b0;
        step();
        check("flags_clear", lamps(), 32'b01000);

        // Reach GATE1_OPEN, then reset aborts without an exit pulse.
        gate2_sw = 1'b0;
        step();
        check("occ2", lamps(), 32'b00010);
        dep_sw = 1'b1; water_low = 1'b0; water_high = 1'b1; gate1_sw = 1'b1;
        step();
        check("gate1_open2", lamps(), 32'b00100);
        reset = 1'b1;
        step();
        check("abort_lamps", lamps(), 32'd0);
        check("abort_count", {24'd0, pass_count}, 32'd0);
        check("abort_dep", {31'd0, dep_li}, 32'd0);
        reset = 1'b0; dep_sw = 1'b0; gate1_sw = 1'b0; water_high = 1'b0;
        step();
        check("abort_no_exit", lamps(), 32'd0);

        // 256 back-to-back passages: counter wraps to 0 on the last one.
        for (int n = 1; n <= 256; n++)
            passage(n, PASS_W'(n % 256));
        check("wrap_final", {24'd0, pass_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
